// File: rtl/epp_i2c_pkg.sv
// epp_i2c_pkg: shared types and constants
// for the EPP byte-level I2C master.
package epp_i2c_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CMD  = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_DIV  = 2'd3;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_WR    = 2;
  localparam int CMD_RD    = 3;
  localparam int CMD_NACK  = 4;

  localparam int ST_BUSY = 0;
  localparam int ST_NACK = 1;
  localparam int ST_DONE = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP
  } state_t;

  typedef logic [1:0] quarter_t;
  typedef logic [2:0] bitcnt_t;

  // Phase that follows START (or opens a CMD without START)
  function automatic state_t byte_or_stop(input logic [4:0] c);
    if (c[CMD_WR] || c[CMD_RD]) return BIT;
    if (c[CMD_STOP]) return STOP;
    return IDLE;
  endfunction

  function automatic state_t first_phase(input logic [4:0] c);
    return c[CMD_START] ? START : byte_or_stop(c);
  endfunction

  // {scl_low, sda_low} for a quarter; dat is the SDA pull in BIT/ACK
  function automatic logic [1:0] line_drive(
    input state_t   s,
    input quarter_t q,
    input logic     dat
  );
    logic [1:0] d;
    d = 2'b00;
    unique case (s)
      START: d = (q == 2'd0) ? 2'b00 :
                 (q == 2'd3) ? 2'b11 : 2'b01;
      BIT,
      ACK:   d = {(q == 2'd0) || (q == 2'd3), dat};
      STOP:  d = (q == 2'd0) ? 2'b11 :
                 (q == 2'd1) ? 2'b01 : 2'b00;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/epp_i2c_tick_gen.sv
// epp_i2c_tick_gen: quarter-bit tick source.
// Counts 0..div; hold pins it at 0 for clock stretching.
module epp_i2c_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !restart && !hold && (cnt >= div);

  // Quarter counter; >= guards against a div shrunk below cnt
  always_ff @(posedge clk) begin
    if (reset || restart || hold) begin
      cnt <= '0;
    end else if (cnt >= div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/epp_i2c_master.sv
// epp_i2c_master: Avalon-MM byte-level I2C master
// driving open-drain SCL/SDA through *_oe pull-downs.
module epp_i2c_master
  import epp_i2c_pkg::*;
#(
  parameter int DIV_DEFAULT = 124,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);

  state_t           state, state_n;
  quarter_t         q, q_n;
  bitcnt_t          bitc, bitc_n;
  logic [4:0]       cmd, cmd_n;
  logic [7:0]       tx, tx_lat, tx_use;
  logic [7:0]       rx, rx_sh;
  logic [DIV_W-1:0] div;
  logic             busy, done, rx_nack;
  logic             wr_en, accept, tick, hold, fin;
  logic             byte_wr, byte_rd, dat;
  logic             scl_n, sda_n;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  assign wr_en  = chipselect && !write_n;
  assign accept = wr_en && (address == ADDR_CMD) &&
                  !busy && (|writedata[4:0]);

  // The command and TX byte are frozen at accept
  assign cmd_n  = accept ? writedata[4:0] : cmd;
  assign tx_use = accept ? tx : tx_lat;

  // WR wins when both byte directions are requested
  assign byte_wr = cmd_n[CMD_WR];
  assign byte_rd = cmd_n[CMD_RD] && !cmd_n[CMD_WR];

  // Stretch: a slave holding SCL low freezes q1
  assign hold = ((state == BIT) || (state == ACK) ||
                 (state == STOP)) &&
                (q == 2'd1) && !scl_in;

  epp_i2c_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .hold   (hold),
    .div    (div),
    .tick   (tick),
    .*
  );

  // Phase sequencing and next line levels
  always_comb begin
    state_n = state;
    q_n     = q;
    bitc_n  = bitc;
    fin     = 1'b0;
    dat     = 1'b0;
    if (accept) begin
      state_n = first_phase(writedata[4:0]);
      q_n     = 2'd0;
      bitc_n  = 3'd7;
    end else if (tick && (state != IDLE)) begin
      q_n = q + 2'd1;
      if (q == 2'd3) begin
        unique case (state)
          START: state_n = byte_or_stop(cmd);
          BIT: begin
            if (bitc == 3'd0) state_n = ACK;
            else bitc_n = bitc - 3'd1;
          end
          ACK:   state_n = cmd[CMD_STOP] ? STOP : IDLE;
          STOP:  state_n = IDLE;
          default: state_n = IDLE;
        endcase
        fin = (state_n == IDLE);
      end
    end
    unique case (state_n)
      BIT:     dat = byte_wr && !tx_use[bitc_n];
      ACK:     dat = byte_rd && !cmd_n[CMD_NACK];
      default: dat = 1'b0;
    endcase
    if (state_n == IDLE) begin
      {scl_n, sda_n} = {scl_oe, sda_oe};
    end else begin
      {scl_n, sda_n} = line_drive(state_n, q_n, dat);
    end
  end

  // FSM state and registered open-drain enables
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q      <= 2'd0;
      bitc   <= 3'd0;
      cmd    <= '0;
      tx_lat <= '0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      bitc   <= bitc_n;
      cmd    <= cmd_n;
      scl_oe <= scl_n;
      sda_oe <= sda_n;
      if (accept) tx_lat <= tx;
    end
  end

  // Read mux, STATUS word built from bit indices
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (address == ADDR_DATA): rd_mux = 32'(rx);
      (address == ADDR_CMD):  rd_mux = '0;
      (address == ADDR_STAT): begin
        rd_mux[ST_BUSY] = busy;
        rd_mux[ST_NACK] = rx_nack;
        rd_mux[ST_DONE] = done;
      end
      (address == ADDR_DIV):  rd_mux = 32'(div);
      default:                rd_mux = '0;
    endcase
  end

  // Registers, status flags, receive shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      tx       <= '0;
      div      <= DIV_W'(DIV_DEFAULT);
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_nack  <= 1'b0;
      rx       <= '0;
      rx_sh    <= '0;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      if (wr_en && (address == ADDR_DATA)) begin
        tx <= writedata[7:0];
      end
      if (wr_en && (address == ADDR_DIV) && !busy) begin
        div <= writedata[DIV_W-1:0];
      end
      if (accept) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (fin || (busy && (state == IDLE))) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (tick && (state == BIT) && (q == 2'd2) && byte_rd) begin
        rx_sh <= {rx_sh[6:0], sda_in};
      end
      if (tick && (state == ACK) && (q == 2'd2) && byte_wr) begin
        rx_nack <= sda_in;
      end
      if (tick && (state == ACK) && (q == 2'd3) && byte_rd) begin
        rx <= rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_epp_i2c_master.sv
// tb_epp_i2c_master: directed bench with a small
// open-drain bus and slave model.
module tb_epp_i2c_master;
  import epp_i2c_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        scl_in, sda_in;
  logic        scl_oe, sda_oe;

  logic        stretch, slave_low;
  logic        rd_mode, ack_en, manual;
  logic [7:0]  rd_byte;
  int          falls = 0;
  int          start_mark = 0;
  int          origin = 0;
  int          slot;
  logic        rise_sda [0:8];
  logic        rise_oe  [0:8];

  int          n_checks = 0;
  int          n_fail = 0;
  int          t = 0;

  always #5 clk = ~clk;

  epp_i2c_master dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe)
  );

  assign scl_in = !scl_oe && !stretch;
  assign sda_in = !sda_oe && !slave_low;

  always @(negedge scl_in) falls = falls + 1;

  always @(negedge sda_in) begin
    if (scl_in) start_mark = falls;
  end

  always_comb begin
    slot = manual ? (falls - origin) : (falls - start_mark - 1);
  end

  always_comb begin
    slave_low = 1'b0;
    if (rd_mode && slot >= 0 && slot <= 7) begin
      slave_low = !rd_byte[3'(7 - slot)];
    end else if (ack_en && slot == 8) begin
      slave_low = 1'b1;
    end
  end

  always @(posedge scl_in) begin
    if (slot >= 0 && slot <= 8) begin
      rise_sda[slot] = sda_in;
      rise_oe[slot]  = sda_oe;
    end
  end

  function automatic logic [7:0] rise_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = rise_sda[i];
    return b;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic bus_write(input logic [1:0] a,
                           input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a,
                          output logic [31:0] d);
    address = a;
    cycle();
    d = readdata;
  endtask

  task automatic wait_idle(input string tag, output int busy_clk);
    int k;
    address = ADDR_STAT;
    for (k = 0; k < 4000; k++) begin
      cycle();
      if (!readdata[ST_BUSY]) break;
    end
    check({tag, "_tmo"}, 32'(k >= 4000), 32'd0);
    busy_clk = t - 1;
  endtask

  task automatic start_cmd(input logic [4:0] c);
    bus_write(ADDR_CMD, 32'(c));
    t = 0;
  endtask

  initial begin
    logic [31:0] d;
    int          b;
    int          k;

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    address = ADDR_DIV; writedata = '0;
    stretch = 1'b0; rd_mode = 1'b0; ack_en = 1'b0;
    manual = 1'b0; rd_byte = '0;

    repeat (3) cycle();
    check("rst_rdata", readdata, 32'd0);
    check("rst_scl", 32'(scl_oe), 32'd0);
    check("rst_sda", 32'(sda_oe), 32'd0);
    reset = 1'b0;
    bus_read(ADDR_STAT, d); check("rst_status", d, 32'd0);
    bus_read(ADDR_DIV, d);  check("rst_div", d, 32'd124);
    bus_read(ADDR_DATA, d); check("rst_rx", d, 32'd0);
    bus_read(ADDR_CMD, d);  check("cmd_reads0", d, 32'd0);

    // Write 0xA5 with START/STOP, slave ACKs
    bus_write(ADDR_DIV, 32'd4);
    bus_read(ADDR_DIV, d); check("div_wr", d, 32'd4);
    bus_write(ADDR_DATA, 32'hA5);
    ack_en = 1'b1;
    start_cmd(5'h07);
    wait_idle("wr", b);
    check("wr_busy", 32'(b), 32'd220);
    check("wr_status", readdata, 32'h4);
    check("wr_bits", 32'(rise_byte()), 32'hA5);
    check("wr_ack_line", 32'(rise_sda[8]), 32'd0);
    check("wr_scl_rel", 32'(scl_oe), 32'd0);
    check("wr_sda_rel", 32'(sda_oe), 32'd0);

    // Read 0x3C with START, master NACKs, no STOP
    ack_en = 1'b0; rd_mode = 1'b1; rd_byte = 8'h3C;
    start_cmd(5'h19);
    wait_idle("rd", b);
    check("rd_busy", 32'(b), 32'd200);
    check("rd_status", readdata, 32'h4);
    check("rd_bits", 32'(rise_byte()), 32'h3C);
    check("rd_nack_oe", 32'(rise_oe[8]), 32'd0);
    check("rd_nack_line", 32'(rise_sda[8]), 32'd1);
    check("rd_scl_held", 32'(scl_oe), 32'd1);
    bus_read(ADDR_DATA, d); check("rd_rx", d, 32'h3C);

    // Bare WR on a held bus, slave does not ACK
    rd_mode = 1'b0;
    bus_write(ADDR_DATA, 32'hC3);
    origin = falls; manual = 1'b1;
    start_cmd(5'h04);
    wait_idle("nak", b);
    check("nak_busy", 32'(b), 32'd180);
    check("nak_status", readdata, 32'h6);
    check("nak_bits", 32'(rise_byte()), 32'hC3);
    manual = 1'b0;

    // Slave stretches SCL 50 clk in bit 3 q1
    ack_en = 1'b1;
    bus_write(ADDR_DATA, 32'h5A);
    start_cmd(5'h07);
    for (k = 0; k < 1000 && slot != 3; k++) cycle();
    check("str_slot_tmo", 32'(k >= 1000), 32'd0);
    stretch = 1'b1;
    for (k = 0; k < 1000 && scl_oe != 1'b0; k++) cycle();
    check("str_q1_tmo", 32'(k >= 1000), 32'd0);
    repeat (50) cycle();
    check("str_scl_low", 32'(scl_in), 32'd0);
    stretch = 1'b0;
    wait_idle("str", b);
    check("str_busy", 32'(b), 32'd270);
    check("str_status", readdata, 32'h4);
    check("str_bits", 32'(rise_byte()), 32'h5A);

    // CMD and DIV writes while busy are ignored
    bus_write(ADDR_DATA, 32'h81);
    start_cmd(5'h07);
    repeat (30) cycle();
    bus_write(ADDR_CMD, 32'h08);
    bus_write(ADDR_DIV, 32'd0);
    wait_idle("ign", b);
    check("ign_busy", 32'(b), 32'd220);
    check("ign_status", readdata, 32'h4);
    check("ign_bits", 32'(rise_byte()), 32'h81);
    bus_read(ADDR_DIV, d); check("ign_div", d, 32'd4);

    // Reset in the middle of bit 2 of a 0x00 write
    bus_write(ADDR_DATA, 32'h00);
    start_cmd(5'h07);
    address = ADDR_STAT;
    repeat (62) cycle();
    check("mid_scl_pre", 32'(scl_oe), 32'd1);
    check("mid_sda_pre", 32'(sda_oe), 32'd1);
    check("mid_busy_pre", 32'(readdata[ST_BUSY]), 32'd1);
    reset = 1'b1;
    cycle();
    check("mid_scl", 32'(scl_oe), 32'd0);
    check("mid_sda", 32'(sda_oe), 32'd0);
    reset = 1'b0;
    bus_read(ADDR_STAT, d); check("mid_status", d, 32'd0);
    repeat (40) cycle();
    check("mid_scl_idle", 32'(scl_oe), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
